// File: rtl/sm_1118_adc_emulator.sv
// ADC128S022 responder: oversampled SPI slave that serves 12-bit channel values from ch_data.
// Optional build macro SM_ADC_EMU_NOISE_EN adds LFSR dither on the two LSBs of each snapshot.
module sm_1118_adc_emulator #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic        adc_sck,
    input  logic        adc_cs_n,
    input  logic        din,
    input  logic [95:0] ch_data,
    output logic        dout,
    output logic        dout_oe,
    output logic        frame_done,
    output logic [2:0]  frame_addr,
    output logic        frame_abort
);

    typedef enum logic {StIdle, StActive} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   cs_prev_q, cs_prev_d;

    logic [4:0]  edge_cnt_q, edge_cnt_d;
    logic [2:0]  addr_sh_q, addr_sh_d;
    logic [2:0]  cur_addr_q, cur_addr_d;
    logic [2:0]  frame_addr_q, frame_addr_d;
    logic [11:0] sh_q, sh_d;
    logic        dout_q, dout_d;
    logic        dout_oe_q, dout_oe_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;

    logic        sck_s, cs_s, din_s;
    logic        sck_rise, sck_fall, cs_fall;
    logic [11:0] ch_sel;
    logic [11:0] snap;
    logic        snap_load;

    always_comb begin
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], adc_sck};
        cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], adc_cs_n};
        din_sync_d = {din_sync_q[SYNC_STAGES-2:0], din};
        sck_s      = sck_sync_q[SYNC_STAGES-1];
        cs_s       = cs_sync_q[SYNC_STAGES-1];
        din_s      = din_sync_q[SYNC_STAGES-1];
        sck_prev_d = sck_s;
        cs_prev_d  = cs_s;
        sck_rise   = sck_s & ~sck_prev_q;
        sck_fall   = ~sck_s & sck_prev_q;
        cs_fall    = ~cs_s & cs_prev_q;
    end

    always_comb begin
        ch_sel = ch_data[11:0];
        for (int i = 0; i < 8; i++) begin
            if (cur_addr_q == 3'(i)) begin
                ch_sel = ch_data[12*i +: 12];
            end
        end
    end

`ifdef SM_ADC_EMU_NOISE_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    always_comb begin
        lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d  = lfsr_q;
        if (snap_load) begin
            lfsr_d = {lfsr_q[14:0], lfsr_fb};
        end
        snap = ch_sel ^ {10'd0, lfsr_q[1:0]};
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    always_comb begin
        snap = ch_sel;
    end
`endif

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        addr_sh_d    = addr_sh_q;
        cur_addr_d   = cur_addr_q;
        frame_addr_d = frame_addr_q;
        sh_d         = sh_q;
        dout_d       = dout_q;
        dout_oe_d    = dout_oe_q;
        done_d       = 1'b0;
        abort_d      = 1'b0;
        snap_load    = 1'b0;

        unique case (state_q)
            StIdle: begin
                dout_d    = 1'b0;
                dout_oe_d = 1'b0;
                if (cs_fall) begin
                    state_d    = StActive;
                    edge_cnt_d = 5'd0;
                    dout_oe_d  = 1'b1;
                end
            end
            StActive: begin
                // cs_n high takes priority over any sck edge seen in the same clk
                if (cs_s) begin
                    state_d   = StIdle;
                    dout_d    = 1'b0;
                    dout_oe_d = 1'b0;
                    abort_d   = (edge_cnt_q != 5'd0) && (edge_cnt_q != 5'd16);
                end else if (sck_rise) begin
                    if (edge_cnt_q inside {[5'd2:5'd4]}) begin
                        addr_sh_d = {addr_sh_q[1:0], din_s};
                    end
                    if (edge_cnt_q >= 5'd15) begin
                        edge_cnt_d   = 5'd0;
                        cur_addr_d   = addr_sh_q;
                        frame_addr_d = addr_sh_q;
                        done_d       = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + 5'd1;
                    end
                end else if (sck_fall) begin
                    // Falling edge k arrives with edge_cnt == k-1 and drives bit k+1
                    if (edge_cnt_q == 5'd3) begin
                        sh_d      = snap;
                        dout_d    = snap[11];
                        snap_load = 1'b1;
                    end else if (edge_cnt_q inside {[5'd4:5'd14]}) begin
                        dout_d = sh_q[10];
                        sh_d   = {sh_q[10:0], 1'b0};
                    end else begin
                        dout_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q   <= '1;
            cs_sync_q    <= '1;
            din_sync_q   <= '0;
            sck_prev_q   <= 1'b1;
            cs_prev_q    <= 1'b1;
            state_q      <= StIdle;
            edge_cnt_q   <= 5'd0;
            addr_sh_q    <= 3'd0;
            cur_addr_q   <= 3'd0;
            frame_addr_q <= 3'd0;
            sh_q         <= 12'd0;
            dout_q       <= 1'b0;
            dout_oe_q    <= 1'b0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            sck_sync_q   <= sck_sync_d;
            cs_sync_q    <= cs_sync_d;
            din_sync_q   <= din_sync_d;
            sck_prev_q   <= sck_prev_d;
            cs_prev_q    <= cs_prev_d;
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            addr_sh_q    <= addr_sh_d;
            cur_addr_q   <= cur_addr_d;
            frame_addr_q <= frame_addr_d;
            sh_q         <= sh_d;
            dout_q       <= dout_d;
            dout_oe_q    <= dout_oe_d;
            done_q       <= done_d;
            abort_q      <= abort_d;
        end
    end

    assign dout        = dout_q;
    assign dout_oe     = dout_oe_q;
    assign frame_done  = done_q;
    assign frame_addr  = frame_addr_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_sm_1118_adc_emulator.sv
// Directed bench for sm_1118_adc_emulator: an SPI master task drives frames and a scoreboard
// queue holds the 16-bit words each frame is expected to return.
module tb_sm_1118_adc_emulator;

    logic        clk_50M;
    logic        rst_n;
    logic        adc_sck;
    logic        adc_cs_n;
    logic        din;
    logic [95:0] ch_data;
    logic        dout;
    logic        dout_oe;
    logic        frame_done;
    logic [2:0]  frame_addr;
    logic        frame_abort;

    int          n_vec;
    int          n_err;
    int          done_cnt;
    int          abort_cnt;
    logic [2:0]  m_cur;
    logic [15:0] sb[$];
    logic [15:0] w;
`ifdef SM_ADC_EMU_NOISE_EN
    logic [15:0] lfsr_m;
    logic [15:0] first_w;
    bit          all_eq;
`endif

    sm_1118_adc_emulator #(
        .SYNC_STAGES(2)
    ) dut (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .adc_sck    (adc_sck),
        .adc_cs_n   (adc_cs_n),
        .din        (din),
        .ch_data    (ch_data),
        .dout       (dout),
        .dout_oe    (dout_oe),
        .frame_done (frame_done),
        .frame_addr (frame_addr),
        .frame_abort(frame_abort)
    );

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    initial begin
        done_cnt  = 0;
        abort_cnt = 0;
    end

    always @(negedge clk_50M) begin
        if (frame_done) done_cnt++;
        if (frame_abort) abort_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    // Half of a 3.125 MHz sck period at 50 MHz
    task automatic half();
        wait_clk(8);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [11:0] v);
        ch_data[12*k +: 12] = v;
    endtask

    function automatic logic [15:0] expect_word();
        logic [11:0] v;
        v = ch_data[12*int'(m_cur) +: 12];
`ifdef SM_ADC_EMU_NOISE_EN
        v = v ^ {10'd0, lfsr_m[1:0]};
        lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`endif
        return {4'd0, v};
    endfunction

    // Bit k is sampled just before falling edge k; address bits go out for rising edges 3..5.
    task automatic spi_frame(input logic [2:0] addr, input int ncyc, input int chg_k,
                             input logic [95:0] chg_val, output logic [15:0] word);
        int idx;
        word = '0;
        for (int k = 1; k <= ncyc; k++) begin
            word[16-k] = dout;
            adc_sck = 1'b0;
            idx = 5 - k;
            din = (k >= 3 && k <= 5) ? addr[idx] : 1'b0;
            half();
            adc_sck = 1'b1;
            if (k == chg_k) ch_data = chg_val;
            half();
        end
        din = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [2:0] addr, input int chg_k,
                             input logic [95:0] chg_val);
        logic [15:0] got;
        logic [15:0] exp;
        sb.push_back(expect_word());
        spi_frame(addr, 16, chg_k, chg_val, got);
        exp = sb.pop_front();
        check(tag, {16'd0, got}, {16'd0, exp});
        w = got;
        m_cur = addr;
    endtask

    task automatic full_frame(input string tag, input logic [2:0] addr, input int chg_k,
                              input logic [95:0] chg_val);
        adc_cs_n = 1'b0;
        half();
        run_frame(tag, addr, chg_k, chg_val);
        check({tag, "_oe"}, {31'd0, dout_oe}, 32'd1);
        adc_cs_n = 1'b1;
        wait_clk(8);
    endtask

    initial begin
        logic [95:0] nv;
        n_vec    = 0;
        n_err    = 0;
        m_cur    = 3'd0;
`ifdef SM_ADC_EMU_NOISE_EN
        lfsr_m   = 16'hACE1;
`endif
        rst_n    = 1'b0;
        adc_sck  = 1'b1;
        adc_cs_n = 1'b1;
        din      = 1'b0;
        ch_data  = '0;
        wait_clk(4);
        check("rst_dout", {31'd0, dout}, 32'd0);
        check("rst_oe", {31'd0, dout_oe}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_abort", {31'd0, frame_abort}, 32'd0);
        check("rst_addr", {29'd0, frame_addr}, 32'd0);
        rst_n = 1'b1;
        wait_clk(4);

        // First frame converts channel 0 and captures address 3
        set_ch(0, 12'h5A5);
        full_frame("f1_word", 3'd3, 0, '0);
        check("f1_done_cnt", done_cnt, 1);
        check("f1_addr", {29'd0, frame_addr}, 32'd3);

        set_ch(3, 12'hABC);
        full_frame("f2_word", 3'd0, 0, '0);
        check("f2_done_cnt", done_cnt, 2);
        check("f2_addr", {29'd0, frame_addr}, 32'd0);

        // Three back-to-back frames under one cs_n low
        set_ch(1, 12'h111);
        set_ch(4, 12'h444);
        set_ch(7, 12'h777);
        adc_cs_n = 1'b0;
        half();
        run_frame("c1_word", 3'd1, 0, '0);
        run_frame("c2_word", 3'd4, 0, '0);
        run_frame("c3_word", 3'd7, 0, '0);
        adc_cs_n = 1'b1;
        wait_clk(8);
        check("cont_done_cnt", done_cnt, 5);
        check("cont_addr", {29'd0, frame_addr}, 32'd7);

        // Abort after 9 rising edges carrying address 6
        adc_cs_n = 1'b0;
        half();
        w = expect_word();
        spi_frame(3'd6, 9, 0, '0, w);
        adc_cs_n = 1'b1;
        wait_clk(8);
        check("abort_cnt", abort_cnt, 1);
        check("abort_oe", {31'd0, dout_oe}, 32'd0);
        check("abort_done_cnt", done_cnt, 5);
        check("abort_addr", {29'd0, frame_addr}, 32'd7);
        full_frame("post_abort_word", 3'd2, 0, '0);
        check("post_abort_addr", {29'd0, frame_addr}, 32'd2);

        // ch_data change after the snapshot must not reach the frame in flight
        set_ch(2, 12'h222);
        nv = ch_data;
        nv[24 +: 12] = 12'hEEE;
        full_frame("chg_word", 3'd5, 4, nv);
        check("chg_abort_cnt", abort_cnt, 1);

        // Reset mid-frame
        set_ch(5, 12'h555);
        adc_cs_n = 1'b0;
        half();
        spi_frame(3'd1, 6, 0, '0, w);
        rst_n = 1'b0;
        @(negedge clk_50M);
        check("mrst_dout", {31'd0, dout}, 32'd0);
        check("mrst_oe", {31'd0, dout_oe}, 32'd0);
        check("mrst_done", {31'd0, frame_done}, 32'd0);
        check("mrst_abort", {31'd0, frame_abort}, 32'd0);
        check("mrst_addr", {29'd0, frame_addr}, 32'd0);
        adc_cs_n = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        m_cur = 3'd0;
`ifdef SM_ADC_EMU_NOISE_EN
        lfsr_m = 16'hACE1;
`endif
        full_frame("post_rst_word", 3'd0, 0, '0);
        check("post_rst_word_ch0", {16'd0, w}, 32'h0000_05A5 ^ {30'd0, w[1:0] ^ 2'b01});

`ifdef SM_ADC_EMU_NOISE_EN
        set_ch(2, 12'h800);
        full_frame("nz_prime", 3'd2, 0, '0);
        all_eq = 1'b1;
        for (int i = 0; i < 8; i++) begin
            full_frame("nz_word", 3'd2, 0, '0);
            check("nz_range", {31'd0, (w >= 16'h0800) && (w <= 16'h0803)}, 32'd1);
            if (i == 0) first_w = w;
            else if (w != first_w) all_eq = 1'b0;
        end
        check("nz_varies", {31'd0, all_eq}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
